// File: rtl/spi_blink_ctrl.sv
// SPI-commanded multi-channel N-pulse blink sequencer with byte status readback.
// Optional BLINK_STATUS_EN: txd_data reports {1, cmd_err, 0, busy[4:0]} instead of a count.
module spi_blink_ctrl #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 7,
    parameter int HALF_PERIOD = 25_000_000,
    parameter int TIMEOUT     = 30_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rxd_flag,
    input  logic [7:0]          rxd_data,
    output logic [7:0]          txd_data,
    output logic [CHANNELS-1:0] blink,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done,
    output logic                cmd_err
);

    localparam int HP_W = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [3:0]          r_ch;
    logic [TO_W-1:0]     r_wait;
    logic [CNT_W-1:0]    r_cnt [CHANNELS];
    logic [HP_W-1:0]     r_tmr [CHANNELS];

    logic [CHANNELS-1:0] w_hdr_hit;
    logic [CHANNELS-1:0] w_ch_hit;
    logic [CHANNELS-1:0] w_load;
    logic [CHANNELS-1:0] w_stop;
    logic                w_hdr_ok;
    logic                w_ch_ok;
    logic                w_latch;
    logic                w_err_set;
    logic                w_err_clr;
    logic [CNT_W-1:0]    w_cnt_val;
    logic [7:0]          w_txd;

    always_comb begin
        w_hdr_hit = '0;
        w_ch_hit  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_hdr_hit[c] = (rxd_data[3:0] == 4'(c));
            w_ch_hit[c]  = (r_ch == 4'(c));
        end
        w_hdr_ok = |w_hdr_hit;
        w_ch_ok  = |w_ch_hit;
    end

    // Parser: one command per rxd_flag, executed in the strobe cycle
    always_comb begin
        w_state_nx = r_state;
        w_load     = '0;
        w_stop     = '0;
        w_latch    = 1'b0;
        w_err_set  = 1'b0;
        w_err_clr  = 1'b0;
        w_cnt_val  = rxd_data[CNT_W-1:0];
        unique case (r_state)
            S_IDLE: begin
                if (rxd_flag && rxd_data[7]) begin
                    unique case (rxd_data[6:5])
                        2'b00: begin
                            w_state_nx = S_WAIT;
                            w_latch    = 1'b1;
                        end
                        2'b01: begin
                            if (w_hdr_ok) w_stop = w_hdr_hit;
                            else          w_err_set = 1'b1;
                        end
                        2'b10: w_stop = '1;
                        2'b11: w_err_clr = 1'b1;
                    endcase
                end
            end
            S_WAIT: begin
                if (rxd_flag) begin
                    w_state_nx = S_IDLE;
                    if (!w_ch_ok)             w_err_set = 1'b1;
                    else if (w_cnt_val == '0) w_stop = w_ch_hit;
                    else                      w_load = w_ch_hit;
                end else if (r_wait == TO_W'(TIMEOUT - 1)) begin
                    w_state_nx = S_IDLE;
                    w_err_set  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_wait  <= '0;
            cmd_err <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_latch) begin
                r_ch   <= rxd_data[3:0];
                r_wait <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_err_set)      cmd_err <= 1'b1;
            else if (w_err_clr) cmd_err <= 1'b0;
        end
    end

    // A pulse ends when its off-phase completes; the last one leaves blink low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink <= '0;
            done  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt[c] <= '0;
                r_tmr[c] <= '0;
            end
        end else begin
            done <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_stop[c]) begin
                    r_cnt[c] <= '0;
                    r_tmr[c] <= '0;
                    blink[c] <= 1'b0;
                end else if (w_load[c]) begin
                    r_cnt[c] <= w_cnt_val;
                    r_tmr[c] <= '0;
                    blink[c] <= 1'b1;
                end else if (r_cnt[c] != '0) begin
                    if (r_tmr[c] == HP_W'(HALF_PERIOD - 1)) begin
                        r_tmr[c] <= '0;
                        if (blink[c]) begin
                            blink[c] <= 1'b0;
                        end else begin
                            r_cnt[c] <= r_cnt[c] - 1'b1;
                            if (r_cnt[c] == CNT_W'(1)) done[c] <= 1'b1;
                            else                       blink[c] <= 1'b1;
                        end
                    end else begin
                        r_tmr[c] <= r_tmr[c] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) busy[c] = (r_cnt[c] != '0);
    end

`ifdef BLINK_STATUS_EN
    logic [15:0] w_busy16;

    always_comb begin
        w_busy16 = 16'(busy);
        w_txd    = {1'b1, cmd_err, 1'b0, w_busy16[4:0]};
    end
`else
    logic [3:0] r_last;
    logic [7:0] w_sel8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= '0;
        end else if (r_state == S_IDLE && rxd_flag && rxd_data[7]
                     && !rxd_data[6] && w_hdr_ok) begin
            r_last <= rxd_data[3:0];
        end
    end

    always_comb begin
        w_sel8 = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_last == 4'(c)) w_sel8 = 8'(r_cnt[c]);
        end
        w_txd = {1'b0, w_sel8[6:0]};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) txd_data <= 8'h00;
        else     txd_data <= w_txd;
    end

endmodule

// File: tb/tb_spi_blink_ctrl.sv
// Scoreboard bench for spi_blink_ctrl: stimulus queues timed expectations,
// a negedge monitor retires them against the DUT outputs.
module tb_spi_blink_ctrl;

    localparam int K_BLINK = 0;
    localparam int K_BUSY  = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERR   = 3;
    localparam int K_TXD   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_flag = 1'b0;
    logic [7:0] rxd_data = 8'h00;
    logic [7:0] txd_data;
    logic [3:0] blink;
    logic [3:0] busy;
    logic [3:0] done;
    logic       cmd_err;

    spi_blink_ctrl #(
        .CHANNELS(4), .CNT_W(7), .HALF_PERIOD(10), .TIMEOUT(20)
    ) dut (
        .clk(clk), .rst(rst), .rxd_flag(rxd_flag), .rxd_data(rxd_data),
        .txd_data(txd_data), .blink(blink), .busy(busy), .done(done),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] mask;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [7:0] sample(int k);
        case (k)
            K_BLINK: return {4'h0, blink};
            K_BUSY:  return {4'h0, busy};
            K_DONE:  return {4'h0, done};
            K_ERR:   return {7'h00, cmd_err};
            default: return txd_data;
        endcase
    endfunction

    task automatic expect_at(input int c, input int k, input logic [7:0] m,
                             input logic [7:0] e, input string nm);
        exp_t x;
        x.cyc = c; x.kind = k; x.mask = m; x.exp = e; x.name = nm;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [7:0] got;
                got = sample(sb[i].kind) & sb[i].mask;
                n_vec++;
                if (got !== (sb[i].exp & sb[i].mask)) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name,
                             cyc, got, sb[i].exp & sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    task automatic send(input logic [7:0] b, output int t);
        @(posedge clk); #1;
        rxd_flag = 1'b1;
        rxd_data = b;
        @(posedge clk); #1;
        rxd_flag = 1'b0;
        rxd_data = 8'h00;
        t = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t1, t2, t3, ts, th, tx, tc, td, t0, c;

        // reset state while rst held
        repeat (2) @(posedge clk);
        #1;
        c = cyc;
        expect_at(c, K_BLINK, 8'h0F, 8'h00, "rst_blink");
        expect_at(c, K_BUSY,  8'h0F, 8'h00, "rst_busy");
        expect_at(c, K_DONE,  8'h0F, 8'h00, "rst_done");
        expect_at(c, K_ERR,   8'h01, 8'h00, "rst_err");
        expect_at(c, K_TXD,   8'hFF, 8'h00, "rst_txd");
        n_vec++;
        if (blink !== 4'h0) begin
            n_err++;
            $display("FAIL d_rst_blink cyc=%0d got=%h exp=0", cyc, blink);
        end
        n_vec++;
        if (busy !== 4'h0) begin
            n_err++;
            $display("FAIL d_rst_busy cyc=%0d got=%h exp=0", cyc, busy);
        end
        n_vec++;
        if (done !== 4'h0) begin
            n_err++;
            $display("FAIL d_rst_done cyc=%0d got=%h exp=0", cyc, done);
        end
        n_vec++;
        if (cmd_err !== 1'b0) begin
            n_err++;
            $display("FAIL d_rst_err cyc=%0d got=%b exp=0", cyc, cmd_err);
        end
        n_vec++;
        if (txd_data !== 8'h00) begin
            n_err++;
            $display("FAIL d_rst_txd cyc=%0d got=%h exp=00", cyc, txd_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // reset in the middle of a START ch1 N=3 run
        send(8'h81, t);
        send(8'h03, t);
        expect_at(t, K_BLINK, 8'h02, 8'h02, "mid_blink_on");
        expect_at(t, K_BUSY,  8'h02, 8'h02, "mid_busy_on");
        wait_until(t + 14);
        c = cyc;
        expect_at(c, K_BLINK, 8'h0F, 8'h00, "async_rst_blink");
        expect_at(c, K_BUSY,  8'h0F, 8'h00, "async_rst_busy");
        expect_at(c, K_DONE,  8'h0F, 8'h00, "async_rst_done");
        expect_at(c, K_ERR,   8'h01, 8'h00, "async_rst_err");
        expect_at(c, K_TXD,   8'hFF, 8'h00, "async_rst_txd");
        rst = 1'b1;
        #1;
        n_vec++;
        if (blink !== 4'h0) begin
            n_err++;
            $display("FAIL d_async_blink cyc=%0d got=%h exp=0", cyc, blink);
        end
        n_vec++;
        if (busy !== 4'h0) begin
            n_err++;
            $display("FAIL d_async_busy cyc=%0d got=%h exp=0", cyc, busy);
        end
        n_vec++;
        if (done !== 4'h0) begin
            n_err++;
            $display("FAIL d_async_done cyc=%0d got=%h exp=0", cyc, done);
        end
        n_vec++;
        if (cmd_err !== 1'b0) begin
            n_err++;
            $display("FAIL d_async_err cyc=%0d got=%b exp=0", cyc, cmd_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h81, t);
        send(8'h01, t);
        expect_at(t,      K_BLINK, 8'h02, 8'h02, "post_rst_on");
        expect_at(t + 9,  K_BLINK, 8'h02, 8'h02, "post_rst_on_end");
        expect_at(t + 10, K_BLINK, 8'h02, 8'h00, "post_rst_off");
        expect_at(t + 19, K_BUSY,  8'h02, 8'h02, "post_rst_busy");
        expect_at(t + 20, K_BUSY,  8'h02, 8'h00, "post_rst_idle");
        expect_at(t + 20, K_DONE,  8'h02, 8'h02, "post_rst_done");
        wait_until(t + 22);

        // START ch0 N=2: full on/off waveform
        send(8'h80, t);
        send(8'h02, t);
        for (int k = 0; k < 42; k++) begin
            logic on;
            on = (k < 40) && ((k / 10) % 2 == 0);
            expect_at(t + k, K_BLINK, 8'h01, {7'h00, on}, "n2_blink");
            expect_at(t + k, K_BUSY, 8'h01, {7'h00, k < 40}, "n2_busy");
            if (k >= 39)
                expect_at(t + k, K_DONE, 8'h01, {7'h00, k == 40}, "n2_done");
        end
        wait_until(t + 43);

        // restart ch2 mid-run, then stop a later run
        send(8'h82, t1);
        send(8'h05, t1);
        wait_until(t1 + 22);
        send(8'h82, t2);
        send(8'h01, t2);
        expect_at(t2,      K_BLINK, 8'h04, 8'h04, "rs_on");
        expect_at(t2 + 9,  K_BLINK, 8'h04, 8'h04, "rs_on_end");
        expect_at(t2 + 10, K_BLINK, 8'h04, 8'h00, "rs_off");
        expect_at(t2 + 19, K_BUSY,  8'h04, 8'h04, "rs_busy");
        expect_at(t2 + 20, K_BUSY,  8'h04, 8'h00, "rs_idle");
        expect_at(t2 + 19, K_DONE,  8'h04, 8'h00, "rs_no_early_done");
        expect_at(t2 + 20, K_DONE,  8'h04, 8'h04, "rs_done");
        wait_until(t2 + 22);
        send(8'h82, t3);
        send(8'h03, t3);
        expect_at(t3 + 2, K_BLINK, 8'h04, 8'h04, "stop_pre_on");
        wait_until(t3 + 4);
        send(8'hA2, ts);
        expect_at(ts, K_BLINK, 8'h04, 8'h00, "stop_blink");
        expect_at(ts, K_BUSY,  8'h04, 8'h00, "stop_busy");
        for (int k = 0; k < 62; k++)
            expect_at(ts + k, K_DONE, 8'h04, 8'h00, "stop_no_done");
        wait_until(ts + 63);

        // timeout, ignored stray byte, CLR_ERR
        send(8'h81, th);
        expect_at(th + 19, K_ERR, 8'h01, 8'h00, "to_before");
        expect_at(th + 20, K_ERR, 8'h01, 8'h01, "to_err");
        wait_until(th + 22);
        send(8'h05, tx);
        expect_at(tx,     K_ERR,   8'h01, 8'h01, "to_sticky");
        expect_at(tx + 1, K_BLINK, 8'h02, 8'h00, "to_ignored_blink");
        expect_at(tx + 3, K_BUSY,  8'h02, 8'h00, "to_ignored_busy");
        wait_until(tx + 4);
        send(8'hE0, tc);
        expect_at(tc, K_ERR, 8'h01, 8'h00, "clr_err");
        wait_until(tc + 2);

        // bad channel START consumes its data byte
        send(8'h87, t);
        expect_at(t, K_ERR, 8'h01, 8'h00, "bad_hdr_no_err");
        send(8'h03, td);
        expect_at(td,     K_ERR,   8'h01, 8'h01, "bad_err");
        expect_at(td + 1, K_BLINK, 8'h0F, 8'h00, "bad_blink");
        expect_at(td + 5, K_BUSY,  8'h0F, 8'h00, "bad_busy");
        wait_until(td + 6);
        send(8'h80, t);
        send(8'h01, t);
        expect_at(t, K_BLINK, 8'h01, 8'h01, "after_bad_start");
        wait_until(t + 22);
        send(8'hE0, tc);
        expect_at(tc, K_ERR, 8'h01, 8'h00, "bad_clr");
        wait_until(tc + 2);

        // readback on ch3, then START N=0 acts as STOP
        send(8'h83, t);
        send(8'h04, t);
`ifdef BLINK_STATUS_EN
        expect_at(t + 1,  K_TXD, 8'hFF, 8'h88, "rb_first");
        expect_at(t + 25, K_TXD, 8'hFF, 8'h88, "rb_period");
`else
        expect_at(t + 1,  K_TXD, 8'hFF, 8'h04, "rb_first");
        expect_at(t + 25, K_TXD, 8'hFF, 8'h03, "rb_period");
`endif
        wait_until(t + 27);
        send(8'h83, t0);
        send(8'h00, t0);
        expect_at(t0, K_BLINK, 8'h08, 8'h00, "n0_blink");
        expect_at(t0, K_BUSY,  8'h08, 8'h00, "n0_busy");
`ifdef BLINK_STATUS_EN
        expect_at(t0 + 1, K_TXD, 8'hFF, 8'h80, "n0_txd");
`else
        expect_at(t0 + 1, K_TXD, 8'hFF, 8'h00, "n0_txd");
`endif
        for (int k = 0; k < 60; k++)
            expect_at(t0 + k, K_DONE, 8'h08, 8'h00, "n0_no_done");
        wait_until(t0 + 62);

        repeat (2) @(posedge clk);
        #1;
        foreach (sb[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL %s expired cyc=%0d got=none exp=%h",
                     sb[i].name, sb[i].cyc, sb[i].exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
